// File: rtl/key_conditioner.sv
// key_conditioner
//   Push-button conditioning. Each key gets a two-flop synchroniser and a
//   debounce counter. Each key then drives a clean level plus one-cycle
//   press and release strobes.
//
//   Optional feature: define KEY_CONDITIONER_AUTOREPEAT_EN to enable
//   per-key auto-repeat. While a key stays down, key_press re-pulses
//   repeat_delay clocks after the accepted press, and then every
//   repeat_period clocks after that.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   key          raw buttons, active high, asynchronous to clk
//   key_level    debounced level per key
//   key_press    one-cycle strobe on an accepted press (or an auto-repeat)
//   key_release  one-cycle strobe on an accepted release
//   any_level    OR of key_level
//   any_press    OR of key_press
module key_conditioner #(
  parameter int w_key           = 4,
  parameter int debounce_cycles = 500000,
  parameter int repeat_delay    = 25000000,
  parameter int repeat_period   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [w_key-1:0] key,
  output logic [w_key-1:0] key_level,
  output logic [w_key-1:0] key_press,
  output logic [w_key-1:0] key_release,
  output logic             any_level,
  output logic             any_press
);

  localparam int CW = $clog2(debounce_cycles);
  localparam logic [CW-1:0] CNT_LAST = CW'(debounce_cycles - 1);

  if (debounce_cycles < 2 || repeat_delay < 1 || repeat_period < 1) begin : g_bad_params
    $error("key_conditioner: debounce_cycles must be >= 2, repeat_delay/repeat_period >= 1");
  end

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RDLY = RW'(repeat_delay);
  localparam logic [RW-1:0] RPER = RW'(repeat_period);
`endif

  for (genvar i = 0; i < w_key; i++) begin : g_key
    logic          s1;
    logic          s2;
    logic          stable;
    logic          prev;
    logic [CW-1:0] cnt;

    // Stage: synchroniser, debounce counter, previous-level register
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        stable <= 1'b0;
        prev   <= 1'b0;
        cnt    <= '0;
      end else begin
        s1   <= key[i];
        s2   <= s1;
        prev <= stable;
        // Any return of s2 to the accepted level restarts qualification,
        // so a bounce shorter than debounce_cycles never gets through.
        if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt != CNT_LAST) begin
          cnt <= cnt + 1'b1;
        end else begin
          stable <= s2;
          cnt    <= '0;
        end
      end
    end

    assign key_level[i]   = stable;
    assign key_release[i] = ~stable & prev;

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    logic [RW-1:0] rcnt;
    logic          rphase;
    logic          rep_hit;

    // rcnt counts the clocks since the last press or repeat pulse. rphase
    // selects the limit: the first-repeat delay first, then the period.
    assign rep_hit = stable & (rcnt == (rphase ? RPER : RDLY));

    // Stage: auto-repeat counter
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (!stable) begin
        rcnt   <= '0;
        rphase <= 1'b0;
      end else if (rep_hit) begin
        rcnt   <= RW'(1);
        rphase <= 1'b1;
      end else begin
        rcnt   <= rcnt + 1'b1;
      end
    end

    assign key_press[i] = (stable & ~prev) | rep_hit;
`else
    assign key_press[i] = stable & ~prev;
`endif
  end

  assign any_level = |key_level;
  assign any_press = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       any_level;
  logic       any_press;

  int n_tests = 0;
  int n_fail  = 0;

  key_conditioner #(
    .w_key          (4),
    .debounce_cycles(4),
    .repeat_delay   (10),
    .repeat_period  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .any_level  (any_level),
    .any_press  (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp_l, exp_p, exp_r;
    key = 4'b1111;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({key_level, key_press, key_release, any_level, any_press} !== 14'd0) begin
      $display("FAIL reset_async lvl=%b prs=%b rel=%b required all 0", key_level, key_press, key_release);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if ({key_level, key_press, key_release, any_level, any_press} !== 14'd0) begin
        $display("FAIL reset_held cyc=%0d lvl=%b prs=%b required all 0", k, key_level, key_press);
        n_fail++;
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_l = (k >= 6) ? 4'b1111 : 4'b0000;
      exp_p = (k == 6) ? 4'b1111 : 4'b0000;
      n_tests++;
      if (key_level !== exp_l || key_press !== exp_p || any_press !== (k == 6)) begin
        $display("FAIL reset_release edge=%0d lvl=%b prs=%b anyp=%b required lvl=%b prs=%b",
                 k, key_level, key_press, any_press, exp_l, exp_p);
        n_fail++;
      end
    end
    key = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_l = (k < 6)  ? 4'b1111 : 4'b0000;
      exp_r = (k == 6) ? 4'b1111 : 4'b0000;
      n_tests++;
      if (key_level !== exp_l || key_release !== exp_r || key_press !== 4'b0000) begin
        $display("FAIL release_all edge=%0d lvl=%b rel=%b prs=%b required lvl=%b rel=%b prs=0000",
                 k, key_level, key_release, key_press, exp_l, exp_r);
        n_fail++;
      end
    end
  endtask

  task automatic test_clean_press_release();
    key[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (key_level !== {3'b000, k >= 6} || key_press !== {3'b000, k == 6} ||
          any_press !== (k == 6) || any_level !== (k >= 6) || key_release !== 4'b0000) begin
        $display("FAIL clean_press edge=%0d lvl=%b prs=%b anyl=%b anyp=%b required lvl=%b prs=%b",
                 k, key_level, key_press, any_level, any_press, {3'b000, k >= 6}, {3'b000, k == 6});
        n_fail++;
      end
    end
    key[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (key_level !== {3'b000, k < 6} || key_release !== {3'b000, k == 6} || key_press !== 4'b0000) begin
        $display("FAIL release edge=%0d lvl=%b rel=%b prs=%b required lvl=%b rel=%b prs=0000",
                 k, key_level, key_release, key_press, {3'b000, k < 6}, {3'b000, k == 6});
        n_fail++;
      end
    end
  endtask

  task automatic test_bounce();
    // Three clocks high: must be rejected.
    key[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) key[1] = 1'b0;
      n_tests++;
      if (key_level !== 4'b0000 || key_press !== 4'b0000 || key_release !== 4'b0000 || any_level !== 1'b0) begin
        $display("FAIL bounce_reject edge=%0d lvl=%b prs=%b rel=%b required all 0",
                 k, key_level, key_press, key_release);
        n_fail++;
      end
    end
    // Four clocks high: exactly the qualification length, accepted.
    key[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) key[1] = 1'b0;
      n_tests++;
      if (key_level !== {2'b00, (k >= 6 && k <= 9), 1'b0} ||
          key_press !== {2'b00, k == 6, 1'b0} || key_release !== {2'b00, k == 10, 1'b0}) begin
        $display("FAIL bounce_accept edge=%0d lvl=%b prs=%b rel=%b required lvl=%b prs=%b rel=%b",
                 k, key_level, key_press, key_release,
                 {2'b00, (k >= 6 && k <= 9), 1'b0}, {2'b00, k == 6, 1'b0}, {2'b00, k == 10, 1'b0});
        n_fail++;
      end
    end
  endtask

  task automatic test_autorepeat();
    logic exp_p;
    key[2] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 20) key[2] = 1'b0;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      exp_p = (k == 6) || (k == 16) || (k == 19) || (k == 22) || (k == 25);
`else
      exp_p = (k == 6);
`endif
      n_tests++;
      if (key_press !== {1'b0, exp_p, 2'b00} || key_level !== {1'b0, (k >= 6 && k <= 25), 2'b00} ||
          key_release !== {1'b0, k == 26, 2'b00}) begin
        $display("FAIL autorepeat edge=%0d lvl=%b prs=%b rel=%b required prs=%b lvl=%b rel=%b",
                 k, key_level, key_press, key_release,
                 {1'b0, exp_p, 2'b00}, {1'b0, (k >= 6 && k <= 25), 2'b00}, {1'b0, k == 26, 2'b00});
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    key[3] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (key_level !== {k >= 6, 3'b000} || key_press !== {k == 6, 3'b000}) begin
        $display("FAIL hold_qualify edge=%0d lvl=%b prs=%b required lvl=%b prs=%b",
                 k, key_level, key_press, {k >= 6, 3'b000}, {k == 6, 3'b000});
        n_fail++;
      end
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (key_level !== 4'b0000 || any_level !== 1'b0 || key_press !== 4'b0000 || key_release !== 4'b0000) begin
      $display("FAIL reset_mid_hold_async lvl=%b anyl=%b prs=%b rel=%b required all 0",
               key_level, any_level, key_press, key_release);
      n_fail++;
    end
    tick();
    tick();
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (key_level !== {k >= 6, 3'b000} || key_press !== {k == 6, 3'b000} || key_release !== 4'b0000) begin
        $display("FAIL reset_requalify edge=%0d lvl=%b prs=%b rel=%b required lvl=%b prs=%b rel=0000",
                 k, key_level, key_press, key_release, {k >= 6, 3'b000}, {k == 6, 3'b000});
        n_fail++;
      end
    end
    key[3] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  initial begin
    rst = 1'b1;
    key = 4'b0000;
    test_reset();
    test_clean_press_release();
    test_bounce();
    test_autorepeat();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage for the board push-buttons. It synchronises each raw `key` bit, debounces it with a per-key qualification counter, and produces clean levels plus one-cycle press and release strobes. It sits directly upstream of the LED shift-register and seven-segment logic, replacing the raw `| key` reduction with `any_level` and `any_press`.

## Interface

Parameters:
- `w_key`, 4: number of keys.
- `debounce_cycles`, 500000: consecutive stable clocks required to accept a change; 10 ms at 50 MHz; minimum 2.
- `repeat_delay`, 25000000: auto-repeat first-repeat delay in clocks; minimum 1.
- `repeat_period`, 5000000: auto-repeat interval in clocks; minimum 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `key` in `w_key`: raw buttons, active-high, asynchronous to `clk`.
- `key_level` out `w_key`: debounced level per key.
- `key_press` out `w_key`: one-cycle strobe per key on an accepted press, or on an auto-repeat.
- `key_release` out `w_key`: one-cycle strobe per key on an accepted release.
- `any_level` out 1: OR of `key_level`.
- `any_press` out 1: OR of `key_press`.

## Operation

Each key has an independent channel. There is no cross-key interaction, and simultaneous events on different keys are handled in parallel.

- **Synchroniser:** two flops, `s1` then `s2`, both reset to 0.
- **Debounce state:** a `stable` bit, reset 0, and a counter `cnt` of width `$clog2(debounce_cycles)`, reset 0.
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt != debounce_cycles-1`: `cnt <= cnt+1`.
  - `s2 != stable` and `cnt == debounce_cycles-1`: `stable <= s2` and `cnt <= 0`.
- **Glitch rejection:** a glitch or bounce shorter than `debounce_cycles` clocks at `s2` resets `cnt` and produces no output change.
- **Outputs:**
  - `key_level = stable`.
  - `key_press` is high only in the first cycle `stable` reads 1.
  - `key_release` is high only in the first cycle `stable` reads 0 after having been 1.
  - Edge strobes come from a registered previous-`stable` bit, reset 0.
- **Press/release pairing:** press and release never assert together on one key, and every release is preceded by exactly one non-repeat press.
- **Reset:**
  - Asserting `rst` (low) clears all flops immediately, so all outputs read 0 asynchronously. This includes mid-debounce and mid-hold.
  - A key still held when `rst` is released is re-qualified from scratch and generates a fresh press.

## Timing

- A clean change on `key[i]` that is settled before rising edge E1 appears on `key_level[i]` after edge E(2+`debounce_cycles`). That is 2 synchroniser edges plus `debounce_cycles` counting edges.
- A change held for exactly `debounce_cycles` clocks at `s2` is accepted. A change held for `debounce_cycles-1` clocks is rejected.
- `key_press` and `key_release` are high for exactly one clock, in the same cycle as the `key_level` transition.
- `any_level` and `any_press` are combinational ORs with no added latency.

## Configuration

The macro `KEY_CONDITIONER_AUTOREPEAT_EN` controls auto-repeat.

When the macro is defined:
- Each key gets a repeat counter, reset 0, cleared whenever `key_level` is 0.
- Let t0 be the first cycle `key_level` is 1. While the level stays high, `key_press` also pulses at t0+`repeat_delay`, then every `repeat_period` clocks after that.
- The counter width is sized for max(`repeat_delay`, `repeat_period`). It saturates nowhere because it wraps per period.
- Release during a countdown cancels it, and no further pulse is produced.

When the macro is undefined:
- Exactly one `key_press` per accepted press.
- The repeat parameters are ignored and no repeat counters are instantiated.

## Test plan

Parameters for all scenarios: `debounce_cycles`=4, `repeat_delay`=10, `repeat_period`=3.

1. **Reset values:** hold `rst`=0 with `key`=4'b1111 -> all outputs 0. Release `rst` -> outputs stay 0 through edge 5, then `key_level`=4'b1111 and `key_press`=4'b1111 for one cycle after edge 6.
2. **Clean press:** `key[0]` goes 0->1 and holds -> `key_level[0]` rises after edge 6, `key_press[0]` and `any_press` are 1 for exactly one cycle, and `any_level`=1.
3. **Bounce rejection:**
   - `key[1]` high for 3 cycles then low -> no change on any output.
   - `key[1]` high for 4 cycles -> accepted, with `key_press[1]` pulsing once.
4. **Release:** `key[0]` goes 1->0 after qualification -> `key_level[0]` falls after edge 6 and `key_release[0]` pulses once. No `key_press` occurs during the release.
5. **Auto-repeat:** hold `key[2]` for 20 cycles after qualification at t0.
   - With the macro: `key_press[2]` pulses at t0, t0+10, t0+13, t0+16 and t0+19, then stops at release.
   - Without the macro: a single pulse at t0.
6. **Reset mid-hold:** with `key[3]` qualified, pulse `rst` low for 2 cycles while the key stays held -> `key_level[3]`=0 immediately. After deassert, `key_level[3]` re-rises after edge 6 with a single `key_press[3]` pulse.
